// File: rtl/alu_pkg.sv
// alu_pkg: op-code encoding, FSM states and decode helpers shared by the ALU top and its mul/div engine.
package alu_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND   = 4'h0;
  localparam logic [CTRL_W-1:0] ALU_OR    = 4'h1;
  localparam logic [CTRL_W-1:0] ALU_ADD   = 4'h2;
  localparam logic [CTRL_W-1:0] ALU_XOR   = 4'h3;
  localparam logic [CTRL_W-1:0] ALU_ANDN  = 4'h4;
  localparam logic [CTRL_W-1:0] ALU_ORN   = 4'h5;
  localparam logic [CTRL_W-1:0] ALU_SUB   = 4'h6;
  localparam logic [CTRL_W-1:0] ALU_SLT   = 4'h7;
  localparam logic [CTRL_W-1:0] ALU_SLTU  = 4'h8;
  localparam logic [CTRL_W-1:0] ALU_NOR   = 4'h9;
  localparam logic [CTRL_W-1:0] ALU_MULT  = 4'hA;
  localparam logic [CTRL_W-1:0] ALU_MULTU = 4'hB;
  localparam logic [CTRL_W-1:0] ALU_DIV   = 4'hC;
  localparam logic [CTRL_W-1:0] ALU_DIVU  = 4'hD;
  localparam logic [CTRL_W-1:0] ALU_MFHI  = 4'hE;
  localparam logic [CTRL_W-1:0] ALU_MFLO  = 4'hF;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  function automatic logic is_muldiv(input logic [CTRL_W-1:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [CTRL_W-1:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [CTRL_W-1:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative shift-add multiplier / restoring divider on operand magnitudes, one bit per cycle.
// The first iteration happens on the start edge, so done is raised while the WIDTH-th iteration is applied.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] ph_q, ph_d, pl_q, pl_d, m_q, m_d, a_q, a_d;
  logic             div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;

  // mul: {ph,pl} shifts right, adding m when the multiplier LSB is set
  // div: {ph,pl} shifts left, quotient bits enter pl from the bottom
  function automatic logic [2*WIDTH-1:0] step(input logic dv, input logic [WIDTH-1:0] ph,
                                              input logic [WIDTH-1:0] pl, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] acc;
    logic [WIDTH:0] sh;
    logic           ge;
    if (dv) begin
      sh  = {ph, pl[WIDTH-1]};
      ge  = (sh >= {1'b0, m});
      acc = ge ? (sh - {1'b0, m}) : sh;
      return {acc[WIDTH-1:0], pl[WIDTH-2:0], ge};
    end else begin
      acc = {1'b0, ph} + (pl[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      return {acc, pl[WIDTH-1:1]};
    end
  endfunction

  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign done  = busy_q && (cnt_q == LAST);

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    ph_d   = ph_q;
    pl_d   = pl_q;
    m_d    = m_q;
    a_d    = a_q;
    div_d  = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    if (start) begin
      {ph_d, pl_d} = step(is_div, '0, a_mag, b_mag);
      m_d    = b_mag;
      a_d    = a;
      div_d  = is_div;
      qneg_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_d = is_signed && a[WIDTH-1];
      dz_d   = is_div && (b == '0);
      cnt_d  = CW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      {ph_d, pl_d} = step(div_q, ph_q, pl_q, m_q);
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  // Sign fix-up is applied on the final magnitudes, read by the top in its FIX state
  always_comb begin
    prod = {ph_q, pl_q};
    if (qneg_q) prod = ~prod + 1'b1;
    hi_out = prod[2*WIDTH-1:WIDTH];
    lo_out = prod[WIDTH-1:0];
    if (div_q) begin
      if (dz_q) begin
        hi_out = a_q;
        lo_out = '1;
      end else begin
        hi_out = rneg_q ? (~ph_q + 1'b1) : ph_q;
        lo_out = qneg_q ? (~pl_q + 1'b1) : pl_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ph_q   <= '0;
      pl_q   <= '0;
      m_q    <= '0;
      a_q    <= '0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      ph_q   <= ph_d;
      pl_q   <= pl_d;
      m_q    <= m_d;
      a_q    <= a_d;
      div_q  <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: registered EX-stage ALU with valid/ready handshake, iterative MULT/DIV and HI/LO.
// Optional signed ADD/SUB overflow flag is built when ALU_OVF_EN is defined.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = alu_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  SrcA,
  input  logic [WIDTH-1:0]  SrcB,
  input  logic [CTRL_W-1:0] ALU_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  ALUResult,
  output logic              zero,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              ovf
);

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d;

  logic             accept, op_muldiv, eng_start, eng_done;
  logic [WIDTH-1:0] alu_res, sum, diff, eng_hi, eng_lo;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign op_muldiv = is_muldiv(ALU_ctrl);
  assign eng_start = accept && op_muldiv;
  assign sum       = SrcA + SrcB;
  assign diff      = SrcA - SrcB;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (eng_start),
    .is_div    (is_div_op(ALU_ctrl)),
    .is_signed (is_signed_op(ALU_ctrl)),
    .a         (SrcA),
    .b         (SrcB),
    .done      (eng_done),
    .hi_out    (eng_hi),
    .lo_out    (eng_lo)
  );

  always_comb begin
    alu_res = '0;
    case (ALU_ctrl)
      ALU_AND:  alu_res = SrcA & SrcB;
      ALU_OR:   alu_res = SrcA | SrcB;
      ALU_ADD:  alu_res = sum;
      ALU_XOR:  alu_res = SrcA ^ SrcB;
      ALU_ANDN: alu_res = SrcA & ~SrcB;
      ALU_ORN:  alu_res = SrcA | ~SrcB;
      ALU_SUB:  alu_res = diff;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      ALU_NOR:  alu_res = ~(SrcA | SrcB);
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_muldiv) begin
            state_d = is_div_op(ALU_ctrl) ? DIV : MUL;
          end else begin
            res_d       = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      MUL, DIV: if (eng_done) state_d = FIX;
      FIX: begin
        hi_d        = eng_hi;
        lo_d        = eng_lo;
        res_d       = eng_lo;
        zero_d      = (eng_lo == '0);
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_q, ovf_d;
  logic add_ovf, sub_ovf;

  assign add_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
  assign sub_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);

  // Tracks ALUResult: updated whenever a new result is registered, cleared for mul/div results
  always_comb begin
    ovf_d = ovf_q;
    if (accept && !op_muldiv)
      ovf_d = ((ALU_ctrl == ALU_ADD) && add_ovf) || ((ALU_ctrl == ALU_SUB) && sub_ovf);
    else if (state_q == FIX)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign ALUResult = res_q;
  assign zero      = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
